round_key_xor_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational round-key XOR.
- Holds a bank of NUM_KEYS round keys, loaded through a write port.
- Accepts state blocks with a round index over valid/ready and returns state XOR selected key after PIPE cycles.
- Encrypt/decrypt index mapping is built in. The block sits between the round datapath (SubBytes/ShiftRows/MixColumns) and the round controller.

---
 rtl/round_key_xor_pipe.sv | 136 +++++++++++++
 tb/tb_round_key_xor_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_xor_pipe.sv
// Pipelined round-key XOR: a loadable bank of round keys, encrypt/decrypt index
// mapping, and a PIPE-deep valid/ready pipeline returning state ^ key.
module round_key_xor_pipe #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 15,
  parameter int PIPE     = 2,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [IDX_W-1:0]  in_round,
  input  logic              in_decrypt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_state,
  output logic [IDX_W-1:0]  out_round,
  output logic              out_err
);

  // One extra bit so NUM_KEYS == 2**IDX_W still compares correctly.
  localparam logic [IDX_W:0]   NUM_KEYS_W = (IDX_W + 1)'(NUM_KEYS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_KEYS - 1);

  logic [DATA_W-1:0] r_key_bank [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_loaded;

  logic              w_wr_hit;
  logic              w_round_oob;
  logic [IDX_W-1:0]  w_eff;
  logic [DATA_W-1:0] w_key_sel;
  logic              w_loaded_sel;
  logic              w_sel_err;
  logic [DATA_W-1:0] w_xor_state;

  logic [PIPE-1:0]             r_valid;
  logic [PIPE-1:0]             r_err;
  logic [PIPE-1:0][DATA_W-1:0] r_state;
  logic [PIPE-1:0][IDX_W-1:0]  r_round;
  logic [PIPE-1:0]             w_adv;

  // key_clr blocks a same-cycle write entirely, so the slot stays unloaded.
  assign w_wr_hit = key_wr_en && !key_clr && ({1'b0, key_wr_idx} < NUM_KEYS_W);

  // NOTE: the bank is reset because reset must leave every slot at zero;
  // this forces flops rather than a RAM macro, which is acceptable at this size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_key_bank[k] <= '0;
      end
      r_loaded <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the same-edge read in the pipeline
      // seeing the old key and loaded bit.
      if (key_clr) begin
        r_loaded <= '0;
      end
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (w_wr_hit && (key_wr_idx == IDX_W'(k))) begin
          r_key_bank[k] <= key_wr_data;
          r_loaded[k]   <= 1'b1;
        end
      end
    end
  end

  assign w_round_oob = !({1'b0, in_round} < NUM_KEYS_W);
  // The wrapped subtraction for an out-of-range round is harmless: w_round_oob flags it.
  assign w_eff = in_decrypt ? (LAST_IDX - in_round) : in_round;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_key_sel    = '0;
    w_loaded_sel = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (w_eff == IDX_W'(k)) begin
        w_key_sel    = r_key_bank[k];
        w_loaded_sel = r_loaded[k];
      end
    end
  end

  assign w_sel_err   = w_round_oob || !w_loaded_sel;
  assign w_xor_state = in_state ^ (w_sel_err ? '0 : w_key_sel);

  // A stage can take new data when it is empty or its content moves on.
  always_comb begin
    w_adv = '0;
    w_adv[PIPE-1] = !r_valid[PIPE-1] || out_ready;
    for (int i = PIPE - 2; i >= 0; i--) begin
      w_adv[i] = !r_valid[i] || w_adv[i+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_err   <= '0;
      r_state <= '0;
      r_round <= '0;
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_state[0] <= w_xor_state;
          r_round[0] <= in_round;
          r_err[0]   <= w_sel_err;
        end
      end
      for (int i = 1; i < PIPE; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) begin
            r_state[i] <= r_state[i-1];
            r_round[i] <= r_round[i-1];
            r_err[i]   <= r_err[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[PIPE-1];
  assign out_state = r_state[PIPE-1];
  assign out_round = r_round[PIPE-1];
  assign out_err   = r_err[PIPE-1];

endmodule

// File: tb/tb_round_key_xor_pipe.sv
// Directed bench for round_key_xor_pipe: vector table plus hand-written
// sequences for streaming with backpressure, same-cycle key writes and reset.
module tb_round_key_xor_pipe;

  localparam int DATA_W   = 128;
  localparam int NUM_KEYS = 15;
  localparam int PIPE     = 2;
  localparam int IDX_W    = 4;

  localparam logic [127:0] S    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] NEWK = 128'hdeadbeef_0badf00d_12345678_cafebabe;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_wr_en;
  logic [IDX_W-1:0]  key_wr_idx;
  logic [DATA_W-1:0] key_wr_data;
  logic              key_clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_state;
  logic [IDX_W-1:0]  in_round;
  logic              in_decrypt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_state;
  logic [IDX_W-1:0]  out_round;
  logic              out_err;

  int n_tests = 0;
  int n_fail  = 0;

  round_key_xor_pipe #(
    .DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS), .PIPE(PIPE), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_clr(key_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_round(in_round), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_round(out_round), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] state;
    logic [3:0]   round;
    logic         dec;
    logic [127:0] exp_state;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rd;
    logic         er;
  } exp_t;

  function automatic logic [127:0] kpat(input int idx);
    return {16{8'(idx)}};
  endfunction

  function automatic logic [127:0] stream_state(input int k);
    return {4{32'hc0de0000 | 32'(k)}};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // All tasks below start and end at a falling edge.
  task automatic load_key(input int idx, input logic [127:0] data);
    key_wr_en   = 1'b1;
    key_wr_idx  = IDX_W'(idx);
    key_wr_data = data;
    @(posedge clk);
    @(negedge clk);
    key_wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int k = 0; k < NUM_KEYS; k++) load_key(k, kpat(k));
  endtask

  task automatic run_vec(input vec_t v);
    in_valid   = 1'b1;
    in_state   = v.state;
    in_round   = v.round;
    in_decrypt = v.dec;
    check({v.name, "_in_ready"}, 128'(in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({v.name, "_early_valid"}, 128'(out_valid), 128'(0));
    @(posedge clk);
    @(negedge clk);
    check({v.name, "_valid"}, 128'(out_valid), 128'(1));
    check({v.name, "_state"}, out_state, v.exp_state);
    check({v.name, "_round"}, 128'(out_round), 128'(v.round));
    check({v.name, "_err"}, 128'(out_err), 128'(v.exp_err));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [127:0] st,
                            input logic [3:0] rd, input logic er);
    int waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_valid"}, 128'(out_valid), 128'(1));
    check({name, "_state"}, out_state, st);
    check({name, "_round"}, 128'(out_round), 128'(rd));
    check({name, "_err"}, 128'(out_err), 128'(er));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    exp_t sb[$];
    exp_t e;
    bit   pat[7];
    int   sent, recv, cyc;
    bit   prev_stall, accept, fire;
    logic [127:0] held_st;
    logic [3:0]   held_rd;
    logic         held_er;

    vecs[0] = '{"enc_r3",     S,        4'd3,  1'b0, S ^ kpat(3),   1'b0};
    vecs[1] = '{"dec_r0",     S,        4'd0,  1'b1, S ^ kpat(14),  1'b0};
    vecs[2] = '{"dec_r14",    S,        4'd14, 1'b1, S,             1'b0};
    vecs[3] = '{"enc_r15",    S,        4'd15, 1'b0, S,             1'b1};
    vecs[4] = '{"dec_r15",    S,        4'd15, 1'b1, S,             1'b1};
    vecs[5] = '{"enc_r7_ones", '1,      4'd7,  1'b0, {16{8'hf8}},   1'b0};
    vecs[6] = '{"dec_r9",     S,        4'd9,  1'b1, S ^ kpat(5),   1'b0};

    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0; key_clr = 1'b0;
    in_valid = 1'b0; in_state = '0; in_round = '0; in_decrypt = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state, 128'(0));
    check("rst_out_round", 128'(out_round), 128'(0));
    check("rst_out_err", 128'(out_err), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    load_all();
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // key_clr together with a write to slot 5: the clear wins.
    key_clr = 1'b1; key_wr_en = 1'b1; key_wr_idx = 4'd5; key_wr_data = kpat(5);
    @(posedge clk);
    @(negedge clk);
    key_clr = 1'b0; key_wr_en = 1'b0;
    v = '{"clr_r5", S, 4'd5, 1'b0, S, 1'b1};
    run_vec(v);

    // Streaming with out_ready pattern 1100101.
    load_all();
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0;
    held_st = '0; held_rd = '0; held_er = 1'b0;
    while (recv < 20 && cyc < 300) begin
      out_ready  = pat[cyc % 7];
      in_valid   = (sent < 20);
      in_state   = stream_state(sent);
      in_round   = IDX_W'(sent % NUM_KEYS);
      in_decrypt = 1'b0;
      #1;
      check("stream_in_ready", 128'(in_ready),
            128'(!((sent - recv) == PIPE && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 128'(out_valid), 128'(1));
        check("stall_state", out_state, held_st);
        check("stall_round", 128'(out_round), 128'(held_rd));
        check("stall_err", 128'(out_err), 128'(held_er));
      end
      accept = in_valid && in_ready;
      fire   = out_valid && out_ready;
      if (fire) begin
        check("stream_sb_nonempty", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("stream_state", out_state, e.st);
          check("stream_round", 128'(out_round), 128'(e.rd));
          check("stream_err", 128'(out_err), 128'(e.er));
        end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      held_st = out_state; held_rd = out_round; held_er = out_err;
      if (accept) begin
        e.st = stream_state(sent) ^ kpat(sent % NUM_KEYS);
        e.rd = 4'(sent % NUM_KEYS);
        e.er = 1'b0;
        sb.push_back(e);
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("stream_recv_count", 128'(recv), 128'(20));
    check("stream_sent_count", 128'(sent), 128'(20));
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Same-cycle accept and write of slot 2: old key for this block, new key for the next.
    in_valid = 1'b1; in_state = S; in_round = 4'd2; in_decrypt = 1'b0;
    key_wr_en = 1'b1; key_wr_idx = 4'd2; key_wr_data = NEWK;
    @(posedge clk);
    @(negedge clk);
    key_wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("same_cycle_old", S ^ kpat(2), 4'd2, 1'b0);
    expect_out("same_cycle_new", S ^ NEWK, 4'd2, 1'b0);

    // Reset with two blocks in flight under backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = S; in_round = 4'd3;
    @(posedge clk);
    @(negedge clk);
    in_state = ~S; in_round = 4'd4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 128'(out_valid), 128'(1));
    check("pre_rst_in_ready", 128'(in_ready), 128'(0));
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 128'(out_valid), 128'(0));
    check("async_rst_state", out_state, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    check("post_rst_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    v = '{"post_rst_unloaded", S, 4'd1, 1'b0, S, 1'b1};
    run_vec(v);
    load_key(1, kpat(1));
    v = '{"post_rst_reloaded", S, 4'd1, 1'b0, S ^ kpat(1), 1'b0};
    run_vec(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
